f_stage_pc_reg: RTL and testbench

- Fetch-stage sequential block sitting directly downstream of the next-PC selector.
- Registers `pc_next` into the architectural fetch PC and drives the instruction-memory address.
- Checks the fetched address for AdEL and captures the F/D pipeline register: PC, instruction, exception code, delay-slot flag.
- Arbitrates reset, exception entry, stall and redirect-flush with a fixed priority.

---
 rtl/f_stage_pc_reg_pkg.sv | 28 ++
 rtl/f_addr_check.sv | 28 ++
 rtl/f_stage_pc_reg.sv | 97 +++++++++
 tb/tb_f_stage_pc_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/f_stage_pc_reg_pkg.sv
// Shared CPU definitions: fetch-region bounds, reset/handler vectors,
// ExcCode values used across pipeline stages, and the F/D register layout.
package f_stage_pc_reg_pkg;

   localparam logic [31:0] CPU_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] CPU_HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] CPU_IM_LO      = 32'h0000_3000;
   localparam logic [31:0] CPU_IM_HI      = 32'h0000_6FFC;

   // CP0 Cause.ExcCode values; later stages raise the ones not used in fetch.
   typedef enum logic [4:0] {
      ExcNone = 5'd0,
      ExcAdEL = 5'd4,
      ExcAdES = 5'd5,
      ExcSyscall = 5'd8,
      ExcRi   = 5'd10,
      ExcOv   = 5'd12
   } exc_code_e;

   // F/D pipeline register contents.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exc_code;
      logic        is_bd;
   } fd_reg_t;

endpackage

// File: rtl/f_addr_check.sv
// Pure combinational address-error detector.
// Flags an address that is misaligned (any bit set in addr[1:0] & align_mask)
// or outside the inclusive window [LO, HI], using unsigned compares.
// Ports:
//   addr       in  32  address to check
//   align_mask in  2   low address bits that must be zero (2'b11 word, 2'b01 half, 2'b00 byte)
//   adel       out 1   address error
module f_addr_check
   import f_stage_pc_reg_pkg::*;
#(
   parameter logic [31:0] LO = CPU_IM_LO,
   parameter logic [31:0] HI = CPU_IM_HI
) (
   input  logic [31:0] addr,
   input  logic [1:0]  align_mask,
   output logic        adel
);

   logic misaligned;
   logic out_of_range;

   always_comb begin
      misaligned   = |(addr[1:0] & align_mask);
      out_of_range = (addr < LO) || (addr > HI);
      adel         = misaligned || out_of_range;
   end

endmodule

// File: rtl/f_stage_pc_reg.sv
// Fetch-stage PC register and F/D pipeline register.
// Registers pc_next into the fetch PC (which is also the IM address), checks the
// fetched address for AdEL and captures PC/instruction/ExcCode/delay-slot flag
// into F/D. Per-edge priority: reset > req > flush > stall > normal.
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   synchronous active-high reset
//   pc_next      in  32  next fetch address
//   stall        in  1   hold PC and F/D
//   req          in  1   exception/interrupt accepted; go to HANDLER_PC
//   flush        in  1   eret redirect; load pc_next, clear F/D
//   D_is_jb      in  1   current D instruction is a branch/jump
//   i_inst_rdata in  32  instruction word at F_pc
//   F_pc         out 32  fetch PC / IM address
//   D_pc         out 32  PC held in F/D
//   D_instr      out 32  instruction held in F/D
//   D_excCode    out 5   ExcCode carried into D
//   D_isBD       out 1   D instruction is in a delay slot
module f_stage_pc_reg
   import f_stage_pc_reg_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
   parameter logic [31:0] HANDLER_PC = CPU_HANDLER_PC,
   parameter logic [31:0] IM_LO      = CPU_IM_LO,
   parameter logic [31:0] IM_HI      = CPU_IM_HI,
   parameter logic [4:0]  EXC_ADEL   = ExcAdEL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        stall,
   input  logic        req,
   input  logic        flush,
   input  logic        D_is_jb,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] F_pc,
   output logic [31:0] D_pc,
   output logic [31:0] D_instr,
   output logic [4:0]  D_excCode,
   output logic        D_isBD
);

   logic [31:0] f_pc_q, f_pc_d;
   fd_reg_t     fd_q, fd_d;

   logic        f_adel;
   logic [31:0] f_instr;
   logic [4:0]  f_exc;

   f_addr_check #(
      .LO (IM_LO),
      .HI (IM_HI)
   ) u_f_addr_check (
      .addr       (f_pc_q),
      .align_mask (2'b11),
      .adel       (f_adel)
   );

   // A faulting fetch never lets the IM word into D; the PC itself is kept
   // so D_pc (and later EPC) shows the bad address.
   always_comb begin
      f_instr = f_adel ? 32'h0 : i_inst_rdata;
      f_exc   = f_adel ? EXC_ADEL : ExcNone;
   end

   always_comb begin
      f_pc_d = f_pc_q;
      fd_d   = fd_q;
      if (req) begin
         f_pc_d = HANDLER_PC;
         fd_d   = '{pc: HANDLER_PC, instr: 32'h0, exc_code: ExcNone, is_bd: 1'b0};
      end else if (flush) begin
         f_pc_d = pc_next;
         fd_d   = '{pc: pc_next, instr: 32'h0, exc_code: ExcNone, is_bd: 1'b0};
      end else if (!stall) begin
         f_pc_d = pc_next;
         fd_d   = '{pc: f_pc_q, instr: f_instr, exc_code: f_exc, is_bd: D_is_jb};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc_q <= RESET_PC;
         fd_q   <= '{pc: RESET_PC, instr: 32'h0, exc_code: ExcNone, is_bd: 1'b0};
      end else begin
         f_pc_q <= f_pc_d;
         fd_q   <= fd_d;
      end
   end

   assign F_pc      = f_pc_q;
   assign D_pc      = fd_q.pc;
   assign D_instr   = fd_q.instr;
   assign D_excCode = fd_q.exc_code;
   assign D_isBD    = fd_q.is_bd;

endmodule

// File: tb/tb_f_stage_pc_reg.sv
module tb_f_stage_pc_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_next = 32'h0;
   logic        stall = 1'b0;
   logic        req = 1'b0;
   logic        flush = 1'b0;
   logic        D_is_jb = 1'b0;
   logic [31:0] i_inst_rdata;
   logic [31:0] F_pc;
   logic [31:0] D_pc;
   logic [31:0] D_instr;
   logic [4:0]  D_excCode;
   logic        D_isBD;

   int checks = 0;
   int errors = 0;

   // Reference state: what the fetch stage should hold after each edge.
   logic [31:0] m_fpc, m_dpc, m_dinstr;
   logic [4:0]  m_dexc;
   logic        m_dbd;

   always #5 clk = ~clk;

   // Instruction memory: a distinct word derived from each address.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign i_inst_rdata = im_word(F_pc);

   function automatic bit bad_fetch(input logic [31:0] a);
      return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
   endfunction

   f_stage_pc_reg dut (
      .clk          (clk),
      .reset        (reset),
      .pc_next      (pc_next),
      .stall        (stall),
      .req          (req),
      .flush        (flush),
      .D_is_jb      (D_is_jb),
      .i_inst_rdata (i_inst_rdata),
      .F_pc         (F_pc),
      .D_pc         (D_pc),
      .D_instr      (D_instr),
      .D_excCode    (D_excCode),
      .D_isBD       (D_isBD)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".F_pc"}, F_pc, m_fpc);
      chk({tag, ".D_pc"}, D_pc, m_dpc);
      chk({tag, ".D_instr"}, D_instr, m_dinstr);
      chk({tag, ".D_excCode"}, {27'h0, D_excCode}, {27'h0, m_dexc});
      chk({tag, ".D_isBD"}, {31'h0, D_isBD}, {31'h0, m_dbd});
   endtask

   // Apply one cycle of inputs, advance the reference, then compare after the edge.
   task automatic step(input string tag, input logic rst, input logic [31:0] pcn,
                       input logic stl, input logic rq, input logic fl, input logic jb);
      reset = rst; pc_next = pcn; stall = stl; req = rq; flush = fl; D_is_jb = jb;
      if (rst) begin
         m_fpc = 32'h3000; m_dpc = 32'h3000; m_dinstr = 0; m_dexc = 0; m_dbd = 0;
      end else if (rq) begin
         m_fpc = 32'h4180; m_dpc = 32'h4180; m_dinstr = 0; m_dexc = 0; m_dbd = 0;
      end else if (fl) begin
         m_fpc = pcn; m_dpc = pcn; m_dinstr = 0; m_dexc = 0; m_dbd = 0;
      end else if (!stl) begin
         m_dpc    = m_fpc;
         m_dinstr = bad_fetch(m_fpc) ? 32'h0 : im_word(m_fpc);
         m_dexc   = bad_fetch(m_fpc) ? 5'd4 : 5'd0;
         m_dbd    = jb;
         m_fpc    = pcn;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic run(input string tag, input logic [31:0] pcn);
      step(tag, 1'b0, pcn, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] pcn;
      logic [31:0] held_d;
      int budget;

      // Reset for two cycles, then sequential fetch.
      step("rst0", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rst1", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_fpc", F_pc, 32'h0000_3000);
      run("seq0", m_fpc + 4);
      chk("seq0_fpc", F_pc, 32'h0000_3004);
      chk("seq0_dinstr", D_instr, im_word(32'h3000));
      run("seq1", m_fpc + 4);
      chk("seq1_fpc", F_pc, 32'h0000_3008);

      // Advance to 0x3010, stall three edges, then release.
      budget = 20;
      while (m_fpc != 32'h3010 && budget > 0) begin
         run("to3010", m_fpc + 4);
         budget--;
      end
      held_d = D_pc;
      for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'h3014, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall_dpc_held", D_pc, held_d);
      run("stall_rel", 32'h3014);
      chk("stall_rel_dpc", D_pc, 32'h0000_3010);

      // req beats both flush and stall.
      budget = 20;
      while (m_fpc != 32'h3020 && budget > 0) begin
         run("to3020", m_fpc + 4);
         budget--;
      end
      step("req", 1'b0, 32'h3024, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("req_fpc", F_pc, 32'h0000_4180);
      chk("req_dpc", D_pc, 32'h0000_4180);

      // Misaligned, below and above the IM window, and wrap-around address.
      run("bad_a", 32'h3002);
      run("bad_b", 32'h2FFC);
      chk("adel_misal_exc", {27'h0, D_excCode}, 32'd4);
      chk("adel_misal_dpc", D_pc, 32'h0000_3002);
      run("bad_c", 32'h7000);
      chk("adel_low_dpc", D_pc, 32'h0000_2FFC);
      run("bad_d", 32'hFFFF_FFFC);
      chk("adel_high_instr", D_instr, 32'h0);
      run("bad_e", 32'h6FFC);
      chk("wrap_fpc", D_pc, 32'hFFFF_FFFC);
      run("edge_hi", 32'h3104);
      chk("edge_hi_exc", {27'h0, D_excCode}, 32'd0);

      // Delay-slot flag follows D_is_jb on normal edges only.
      step("bd1", 1'b0, 32'h3108, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bd1_dpc", D_pc, 32'h0000_3104);
      chk("bd1_isbd", {31'h0, D_isBD}, 32'd1);
      run("bd0", 32'h310C);
      chk("bd0_isbd", {31'h0, D_isBD}, 32'd0);

      // Flush while stalled: load EPC, clear F/D.
      step("flush", 1'b0, 32'h3040, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush_fpc", F_pc, 32'h0000_3040);
      chk("flush_dpc", D_pc, 32'h0000_3040);

      // Randomised traffic against the reference.
      for (int n = 0; n < 400; n++) begin
         int r;
         r = int'($urandom_range(0, 15));
         if (r < 11) pcn = m_fpc + 4;
         else if (r == 11) pcn = $urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC;
         else if (r == 12) pcn = $urandom;
         else if (r == 13) pcn = 32'hFFFF_FFFC;
         else if (r == 14) pcn = m_fpc + 2;
         else pcn = 32'h6FFC;
         step("rand", ($urandom_range(0, 49) == 0), pcn, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
